// File: rtl/ofifo_align_if.sv
// Handshake/data bundle between the PE array bottom row and the SFP stage.
// Optional o_err is present only when OFIFO_ERR_FLAG_EN is defined.
interface ofifo_align_if #(
  parameter int col = 8,
  parameter int bw  = 16
);
  logic [col*bw-1:0] in;
  logic [col-1:0]    wr;
  logic              rd;
  logic [col*bw-1:0] out;
  logic              o_valid;
  logic              o_full;
  logic              o_ready;
`ifdef OFIFO_ERR_FLAG_EN
  logic              o_err;

  modport master (output in, wr, rd, input out, o_valid, o_full, o_ready, o_err);
  modport slave  (input in, wr, rd, output out, o_valid, o_full, o_ready, o_err);
`else
  modport master (output in, wr, rd, input out, o_valid, o_full, o_ready);
  modport slave  (input in, wr, rd, output out, o_valid, o_full, o_ready);
`endif
endinterface

// File: rtl/ofifo_align.sv
// Output FIFO with one independent circular buffer per array column.
// A row is offered (first-word fall-through) only when every column holds
// data; a pop advances all columns together.
// Optional sticky overflow/underflow flag: define OFIFO_ERR_FLAG_EN.
module ofifo_align #(
  parameter int col   = 8,
  parameter int bw    = 16,
  parameter int depth = 64
) (
  input  logic         clk,
  input  logic         reset,
  ofifo_align_if.slave bus
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] ptr_one = {{aw{1'b0}}, 1'b1};

  logic [bw-1:0]     mem  [col][depth];
  logic [aw:0]       wptr [col];
  logic [aw:0]       rptr [col];
  logic [col-1:0]    empty;
  logic [col-1:0]    full;
  logic [col-1:0]    accept;
  logic              valid;
  logic              pop_fire;
  logic [col*bw-1:0] head_row;

  // Per-column flags from registered pointers; the extra MSB separates full from empty.
  always_comb begin
    empty = '0;
    full  = '0;
    for (int i = 0; i < col; i++) begin
      empty[i] = (wptr[i] == rptr[i]);
      full[i]  = (wptr[i][aw-1:0] == rptr[i][aw-1:0]) && (wptr[i][aw] != rptr[i][aw]);
    end
  end

  assign valid    = &(~empty);
  assign pop_fire = bus.rd & valid;
  // A full column still takes a write when the same edge frees a slot.
  assign accept   = bus.wr & (~full | {col{pop_fire}});

  // Fall-through read: each lane shows its column's head entry.
  always_comb begin
    head_row = '0;
    for (int i = 0; i < col; i++) begin
      head_row[bw*i +: bw] = mem[i][rptr[i][aw-1:0]];
    end
  end

  assign bus.out     = head_row;
  assign bus.o_valid = valid;
  assign bus.o_full  = |full;
  assign bus.o_ready = ~(|full);

  // Pointer update; reset discards all buffered rows.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < col; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < col; i++) begin
        if (accept[i]) wptr[i] <= wptr[i] + ptr_one;
        if (pop_fire)  rptr[i] <= rptr[i] + ptr_one;
      end
    end
  end

  // Storage writes; contents are intentionally left uncleared by reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < col; i++) begin
      if (accept[i]) mem[i][wptr[i][aw-1:0]] <= bus.in[bw*i +: bw];
    end
  end

`ifdef OFIFO_ERR_FLAG_EN
  logic err_q;

  // Sticky error: dropped write to a full column, or pop request with no row.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if ((|(bus.wr & full & ~{col{pop_fire}})) || (bus.rd && !valid)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.o_err = err_q;
`endif
endmodule
